// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter
//   Shares one single-port data memory between two requesters:
//   port 0 (core load/store unit) and port 1 (loader / debug DMA).
//   Grants one request at a time, latches it, runs a single memory
//   access cycle and returns a one-cycle response pulse. Misaligned and
//   illegal-mask requests are answered with an error and never reach the
//   memory, so maskmode 2'b11 (which would zero a word) is never issued.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   rqN_valid / rqN_ready     request handshake (N = 0, 1)
//   rqN_write                 1 = store, 0 = load
//   rqN_addr / rqN_wdata      byte address / store data
//   rqN_maskmode              00 byte, 01 half, 10 word, 11 illegal
//   rqN_sext                  sign-extend flag passed to the memory
//   rspN_valid                one-cycle response pulse
//   rspN_rdata / rspN_err     load data (0 for stores/errors) / rejected flag
//   mem_*                     memory command, driven only during ACCESS
//   mem_rdata                 combinational read data from the memory
//
// Parameters
//   DATA_WIDTH  data and address width
//   FIXED_PRIO  0: round-robin on ties, 1: port 0 always wins a tie
module dmem_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rq0_valid,
  output logic                  rq0_ready,
  input  logic                  rq0_write,
  input  logic [DATA_WIDTH-1:0] rq0_addr,
  input  logic [DATA_WIDTH-1:0] rq0_wdata,
  input  logic [1:0]            rq0_maskmode,
  input  logic                  rq0_sext,
  input  logic                  rq1_valid,
  output logic                  rq1_ready,
  input  logic                  rq1_write,
  input  logic [DATA_WIDTH-1:0] rq1_addr,
  input  logic [DATA_WIDTH-1:0] rq1_wdata,
  input  logic [1:0]            rq1_maskmode,
  input  logic                  rq1_sext,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  logic [1:0]            state_reg, state_next;
  logic                  last_grant_reg;
  logic                  lat_write_reg;
  logic                  lat_sext_reg;
  logic                  lat_port_reg;
  logic [1:0]            lat_maskmode_reg;
  logic [DATA_WIDTH-1:0] lat_addr_reg;
  logic [DATA_WIDTH-1:0] lat_wdata_reg;
  logic                  rsp_err_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;

  logic                  grant;
  logic                  accept;
  logic                  sel_write;
  logic                  sel_sext;
  logic [1:0]            sel_maskmode;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_err;
  logic                  access_on;
  logic                  resp_on;
  logic [1:0]            ready_vec;
  logic [1:0]            rsp_valid_vec;

  // Grant selection. On a tie round-robin hands the slot to the port that
  // did not win last time; a lone valid port is always granted.
  // Accept is masked by rst so ready never claims a handshake that the
  // reset is about to discard.
  always_comb begin
    if (rq0_valid && rq1_valid) begin
      grant = FIXED_PRIO ? 1'b0 : ~last_grant_reg;
    end else begin
      grant = ~rq0_valid;
    end
    accept = (state_reg == ST_IDLE) && (rq0_valid || rq1_valid) && !rst;
  end

  always_comb begin
    sel_write    = grant ? rq1_write    : rq0_write;
    sel_sext     = grant ? rq1_sext     : rq0_sext;
    sel_maskmode = grant ? rq1_maskmode : rq0_maskmode;
    sel_addr     = grant ? rq1_addr     : rq0_addr;
    sel_wdata    = grant ? rq1_wdata    : rq0_wdata;
    sel_err      = (sel_maskmode == 2'b11) ||
                   ((sel_maskmode == 2'b01) && sel_addr[0]) ||
                   ((sel_maskmode == 2'b10) && (sel_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = sel_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      last_grant_reg   <= 1'b1;   // port 0 wins the first tie
      lat_write_reg    <= 1'b0;
      lat_sext_reg     <= 1'b0;
      lat_port_reg     <= 1'b0;
      lat_maskmode_reg <= 2'b00;
      lat_addr_reg     <= '0;
      lat_wdata_reg    <= '0;
      rsp_err_reg      <= 1'b0;
      rsp_rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_grant_reg   <= grant;
        lat_write_reg    <= sel_write;
        lat_sext_reg     <= sel_sext;
        lat_port_reg     <= grant;
        lat_maskmode_reg <= sel_maskmode;
        lat_addr_reg     <= sel_addr;
        lat_wdata_reg    <= sel_wdata;
        rsp_err_reg      <= sel_err;
        rsp_rdata_reg    <= '0;   // stays 0 for rejected requests
      end
      if (state_reg == ST_ACCESS) begin
        rsp_rdata_reg <= lat_write_reg ? '0 : mem_rdata;
      end
    end
  end

  assign access_on = (state_reg == ST_ACCESS);
  // A reset during RESP discards the pending response.
  assign resp_on   = (state_reg == ST_RESP) && !rst;

  // The memory commits writes on the falling edge, so gating with rst here
  // is what keeps a reset in the ACCESS cycle from corrupting memory.
  assign mem_write    = access_on & lat_write_reg & ~rst;
  assign mem_read     = access_on & ~lat_write_reg;
  assign mem_maskmode = access_on ? lat_maskmode_reg : 2'b00;
  assign mem_sext     = access_on & lat_sext_reg;
  assign mem_address  = access_on ? lat_addr_reg  : '0;
  assign mem_wdata    = access_on ? lat_wdata_reg : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign ready_vec[gi]     = accept  & (grant        == 1'(gi));
      assign rsp_valid_vec[gi] = resp_on & (lat_port_reg == 1'(gi));
    end
  endgenerate

  assign rq0_ready  = ready_vec[0];
  assign rq1_ready  = ready_vec[1];
  assign rsp0_valid = rsp_valid_vec[0];
  assign rsp1_valid = rsp_valid_vec[1];
  assign rsp0_err   = rsp_valid_vec[0] & rsp_err_reg;
  assign rsp1_err   = rsp_valid_vec[1] & rsp_err_reg;
  assign rsp0_rdata = rsp_valid_vec[0] ? rsp_rdata_reg : '0;
  assign rsp1_rdata = rsp_valid_vec[1] ? rsp_rdata_reg : '0;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Testbench for dmem_access_arbiter: directed scenarios plus a randomized
// two-requester run checked against a transaction-level reference model.
module tb_dmem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq0_valid, rq0_write, rq0_sext;
  logic [31:0] rq0_addr, rq0_wdata;
  logic [1:0]  rq0_maskmode;
  logic        rq1_valid, rq1_write, rq1_sext;
  logic [31:0] rq1_addr, rq1_wdata;
  logic [1:0]  rq1_maskmode;
  logic        rq0_ready, rq1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_write, mem_read, mem_sext;
  logic [1:0]  mem_maskmode;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  // second instance, fixed priority, only its grants are observed
  logic        f_rq0_ready, f_rq1_ready;
  logic        f_rsp0_valid, f_rsp0_err, f_rsp1_valid, f_rsp1_err;
  logic [31:0] f_rsp0_rdata, f_rsp1_rdata;
  logic        f_mem_write, f_mem_read, f_mem_sext;
  logic [1:0]  f_mem_maskmode;
  logic [31:0] f_mem_address, f_mem_wdata;
  wire  [31:0] f_mem_rdata = 32'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_access_arbiter #(.DATA_WIDTH(32), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_write(rq0_write),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_maskmode(rq0_maskmode),
    .rq0_sext(rq0_sext),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_write(rq1_write),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_maskmode(rq1_maskmode),
    .rq1_sext(rq1_sext),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_maskmode(mem_maskmode),
    .mem_sext(mem_sext), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_access_arbiter #(.DATA_WIDTH(32), .FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(f_rq0_ready), .rq0_write(rq0_write),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_maskmode(rq0_maskmode),
    .rq0_sext(rq0_sext),
    .rq1_valid(rq1_valid), .rq1_ready(f_rq1_ready), .rq1_write(rq1_write),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_maskmode(rq1_maskmode),
    .rq1_sext(rq1_sext),
    .rsp0_valid(f_rsp0_valid), .rsp0_rdata(f_rsp0_rdata), .rsp0_err(f_rsp0_err),
    .rsp1_valid(f_rsp1_valid), .rsp1_rdata(f_rsp1_rdata), .rsp1_err(f_rsp1_err),
    .mem_write(f_mem_write), .mem_read(f_mem_read), .mem_maskmode(f_mem_maskmode),
    .mem_sext(f_mem_sext), .mem_address(f_mem_address), .mem_wdata(f_mem_wdata),
    .mem_rdata(f_mem_rdata)
  );

  // ---------------- data memory model (256 bytes, little-endian) ----------
  logic [7:0]  mem_bytes [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_word;
  wire  [7:0]  ma = mem_address[7:0];
  logic [7:0]  rb0, rb1, rb2, rb3;

  always @(negedge clk) begin
    if (pl_en) begin
      mem_bytes[pl_addr]       <= pl_word[7:0];
      mem_bytes[pl_addr+8'd1]  <= pl_word[15:8];
      mem_bytes[pl_addr+8'd2]  <= pl_word[23:16];
      mem_bytes[pl_addr+8'd3]  <= pl_word[31:24];
    end else if (mem_write) begin
      case (mem_maskmode)
        2'b00: mem_bytes[ma] <= mem_wdata[7:0];
        2'b01: begin
          mem_bytes[ma]      <= mem_wdata[7:0];
          mem_bytes[ma+8'd1] <= mem_wdata[15:8];
        end
        2'b10: begin
          mem_bytes[ma]      <= mem_wdata[7:0];
          mem_bytes[ma+8'd1] <= mem_wdata[15:8];
          mem_bytes[ma+8'd2] <= mem_wdata[23:16];
          mem_bytes[ma+8'd3] <= mem_wdata[31:24];
        end
        default: begin
          mem_bytes[ma]      <= 8'h00;
          mem_bytes[ma+8'd1] <= 8'h00;
          mem_bytes[ma+8'd2] <= 8'h00;
          mem_bytes[ma+8'd3] <= 8'h00;
        end
      endcase
    end
  end

  assign rb0 = mem_bytes[ma];
  assign rb1 = mem_bytes[ma+8'd1];
  assign rb2 = mem_bytes[ma+8'd2];
  assign rb3 = mem_bytes[ma+8'd3];

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_read) begin
      case (mem_maskmode)
        2'b00:   mem_rdata = mem_sext ? {{24{rb0[7]}}, rb0} : {24'h0, rb0};
        2'b01:   mem_rdata = mem_sext ? {{16{rb1[7]}}, rb1, rb0} : {16'h0, rb1, rb0};
        default: mem_rdata = {rb3, rb2, rb1, rb0};
      endcase
    end
  end

  // ---------------- reference model state --------------------------------
  logic [7:0] shadow [0:255];

  function automatic logic [31:0] shadow_read(input logic [7:0] a, input logic [1:0] mm,
                                              input logic s);
    logic [7:0] b0, b1, b2, b3;
    b0 = shadow[a]; b1 = shadow[a+8'd1]; b2 = shadow[a+8'd2]; b3 = shadow[a+8'd3];
    if (mm == 2'b00) return s ? {{24{b0[7]}}, b0} : {24'h0, b0};
    if (mm == 2'b01) return s ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
    return {b3, b2, b1, b0};
  endfunction

  task automatic shadow_write(input logic [7:0] a, input logic [1:0] mm, input logic [31:0] d);
    shadow[a] = d[7:0];
    if (mm != 2'b00) shadow[a+8'd1] = d[15:8];
    if (mm == 2'b10) begin
      shadow[a+8'd2] = d[23:16];
      shadow[a+8'd3] = d[31:24];
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem_bytes[a+8'd3], mem_bytes[a+8'd2], mem_bytes[a+8'd1], mem_bytes[a]};
  endfunction

  // inputs change 1 time unit after posedge; outputs are sampled 3 later
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_word = w;
    @(negedge clk); #1;
    pl_en = 1'b0;
    shadow_write(a, 2'b10, w);
  endtask

  // ---------------- directed scenarios -----------------------------------
  task automatic test_reset();
    tick(); rst = 1'b1;
    rq0_valid = 1'b1; rq0_addr = 32'h10; rq0_maskmode = 2'b10;
    rq1_valid = 1'b1; rq1_addr = 32'h20; rq1_maskmode = 2'b10;
    tick(); #3;
    tests++; if ({rq0_ready, rq1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err,
                  mem_write, mem_read, mem_sext, mem_maskmode} !== 11'h0) begin
      fails++; $display("FAIL reset_ctrl: got ready=%b%b mem_rw=%b%b want all 0",
                        rq0_ready, rq1_ready, mem_read, mem_write); end
    tests++; if ((rsp0_rdata | rsp1_rdata | mem_address | mem_wdata) !== 32'h0) begin
      fails++; $display("FAIL reset_data: got nonzero data outputs want 0"); end
    tick(); rst = 1'b0; rq0_valid = 1'b0; rq1_valid = 1'b0; #3;
    tests++; if ({rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, mem_read, mem_write} !== 6'h0) begin
      fails++; $display("FAIL idle_quiet: got %b want 000000",
                        {rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, mem_read, mem_write}); end
    $display("[TB] reset check done");
  endtask

  task automatic test_word_load();
    preload(8'h10, 32'hDEADBEEF);
    tick(); rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 32'h10; rq0_maskmode = 2'b10;
    rq0_sext = 1'b0; rq0_wdata = 32'h0; #3;
    tests++; if (rq0_ready !== 1'b1 || rq1_ready !== 1'b0) begin
      fails++; $display("FAIL wl_ready: got %b%b want 10", rq0_ready, rq1_ready); end
    tick(); rq0_valid = 1'b0; #3;
    tests++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h10) begin
      fails++; $display("FAIL wl_access: got rd=%b wr=%b addr=%h want 1 0 10",
                        mem_read, mem_write, mem_address); end
    tests++; if (rsp0_valid !== 1'b0) begin
      fails++; $display("FAIL wl_early_rsp: got %b want 0", rsp0_valid); end
    tick(); #3;
    tests++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEEF || rsp0_err !== 1'b0) begin
      fails++; $display("FAIL wl_rsp: got v=%b d=%h e=%b want 1 deadbeef 0",
                        rsp0_valid, rsp0_rdata, rsp0_err); end
    tests++; if (rsp1_valid !== 1'b0 || mem_read !== 1'b0) begin
      fails++; $display("FAIL wl_rsp_side: got rsp1=%b rd=%b want 0 0", rsp1_valid, mem_read); end
    $display("[TB] txn port0 load word @10 -> %h", rsp0_rdata);
    tick(); #3;
    tests++; if (rsp0_valid !== 1'b0) begin
      fails++; $display("FAIL wl_pulse_len: got %b want 0", rsp0_valid); end
  endtask

  task automatic test_byte_store();
    preload(8'h20, 32'h11223344);
    tick(); rq1_valid = 1'b1; rq1_write = 1'b1; rq1_addr = 32'h20; rq1_maskmode = 2'b00;
    rq1_sext = 1'b0; rq1_wdata = 32'h5A5A5AAB; #3;
    tests++; if (rq1_ready !== 1'b1 || rq0_ready !== 1'b0) begin
      fails++; $display("FAIL bs_ready: got %b%b want 01", rq0_ready, rq1_ready); end
    tick(); rq1_valid = 1'b0; #3;
    tests++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_maskmode !== 2'b00 ||
                 mem_address !== 32'h20 || mem_wdata !== 32'h5A5A5AAB) begin
      fails++; $display("FAIL bs_access: got wr=%b rd=%b mm=%b a=%h d=%h want 1 0 00 20 5a5a5aab",
                        mem_write, mem_read, mem_maskmode, mem_address, mem_wdata); end
    tick(); #3;
    tests++; if (mem_write !== 1'b0 || rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h0 ||
                 rsp1_err !== 1'b0) begin
      fails++; $display("FAIL bs_rsp: got wr=%b v=%b d=%h e=%b want 0 1 0 0",
                        mem_write, rsp1_valid, rsp1_rdata, rsp1_err); end
    $display("[TB] txn port1 store byte @20 <- ab");
    tick(); rq1_valid = 1'b1; rq1_write = 1'b0; rq1_maskmode = 2'b10; #3;
    tests++; if (rq1_ready !== 1'b1) begin
      fails++; $display("FAIL bs_reload_ready: got %b want 1", rq1_ready); end
    tick(); rq1_valid = 1'b0;
    tick(); #3;
    tests++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h112233AB) begin
      fails++; $display("FAIL bs_readback: got v=%b d=%h want 1 112233ab", rsp1_valid, rsp1_rdata); end
    $display("[TB] txn port1 load word @20 -> %h", rsp1_rdata);
  endtask

  task automatic test_alternate();
    logic e0, e1;
    tick(); rst = 1'b1;
    rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 32'h10; rq0_maskmode = 2'b10;
    rq1_valid = 1'b1; rq1_write = 1'b0; rq1_addr = 32'h20; rq1_maskmode = 2'b10;
    tick(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) tick();
      #3;
      // a grant opportunity every third cycle; grant k goes to port k%2
      e0 = (i % 3 == 0) && ((i / 3) % 2 == 0);
      e1 = (i % 3 == 0) && ((i / 3) % 2 == 1);
      tests++; if (rq0_ready !== e0 || rq1_ready !== e1) begin
        fails++; $display("FAIL rr_grant cyc%0d: got %b%b want %b%b", i, rq0_ready, rq1_ready, e0, e1); end
      tests++; if (f_rq0_ready !== (i % 3 == 0) || f_rq1_ready !== 1'b0) begin
        fails++; $display("FAIL fixed_grant cyc%0d: got %b%b want %b0", i, f_rq0_ready, f_rq1_ready,
                          (i % 3 == 0)); end
      if (i % 3 == 0) $display("[TB] txn tie grant rr=%0d fixed=0", rq1_ready);
    end
    tick(); rq0_valid = 1'b0; rq1_valid = 1'b0;
  endtask

  task automatic test_errors();
    logic [1:0]  mm_tab [3];
    logic [31:0] ad_tab [3];
    logic        wr_tab [3];
    mm_tab = '{2'b11, 2'b01, 2'b10};
    ad_tab = '{32'h40, 32'h03, 32'h42};
    wr_tab = '{1'b1, 1'b0, 1'b1};
    preload(8'h40, 32'h0BADF00D);
    for (int c = 0; c < 3; c++) begin
      tick(); rq0_valid = 1'b1; rq0_write = wr_tab[c]; rq0_addr = ad_tab[c];
      rq0_maskmode = mm_tab[c]; rq0_wdata = 32'hFFFFFFFF; #3;
      tests++; if (rq0_ready !== 1'b1) begin
        fails++; $display("FAIL err%0d_ready: got %b want 1", c, rq0_ready); end
      tick(); rq0_valid = 1'b0; #3;
      tests++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_rdata !== 32'h0) begin
        fails++; $display("FAIL err%0d_rsp: got v=%b e=%b d=%h want 1 1 0", c, rsp0_valid, rsp0_err,
                          rsp0_rdata); end
      tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
        fails++; $display("FAIL err%0d_nomem: got rd=%b wr=%b want 0 0", c, mem_read, mem_write); end
      $display("[TB] txn port0 rejected mm=%b addr=%h", mm_tab[c], ad_tab[c]);
      tick(); #3;
      tests++; if (rsp0_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
        fails++; $display("FAIL err%0d_after: got v=%b rd=%b wr=%b want 0 0 0", c, rsp0_valid,
                          mem_read, mem_write); end
    end
    tests++; if (mem_word(8'h40) !== 32'h0BADF00D) begin
      fails++; $display("FAIL err_mem_intact: got %h want 0badf00d", mem_word(8'h40)); end
  endtask

  task automatic test_reset_in_access();
    preload(8'h30, 32'h01020304);
    tick(); rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 32'h30; rq0_maskmode = 2'b10;
    rq0_wdata = 32'hCAFEF00D; #3;
    tests++; if (rq0_ready !== 1'b1) begin
      fails++; $display("FAIL ra_ready: got %b want 1", rq0_ready); end
    tick(); rq0_valid = 1'b0; rst = 1'b1; #3;
    tests++; if (mem_write !== 1'b0) begin
      fails++; $display("FAIL ra_write_gated: got %b want 0", mem_write); end
    tick(); rst = 1'b0; #3;
    tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || mem_write !== 1'b0) begin
      fails++; $display("FAIL ra_no_rsp: got v0=%b v1=%b wr=%b want 0 0 0", rsp0_valid, rsp1_valid,
                        mem_write); end
    tests++; if (mem_word(8'h30) !== 32'h01020304) begin
      fails++; $display("FAIL ra_mem_intact: got %h want 01020304", mem_word(8'h30)); end
    tick(); rq0_valid = 1'b1; rq0_write = 1'b0; #3;
    tests++; if (rq0_ready !== 1'b1) begin
      fails++; $display("FAIL ra_idle_ready: got %b want 1", rq0_ready); end
    tick(); rq0_valid = 1'b0;
    tick(); #3;
    tests++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h01020304) begin
      fails++; $display("FAIL ra_readback: got v=%b d=%h want 1 01020304", rsp0_valid, rsp0_rdata); end
    $display("[TB] txn port0 store aborted by reset, word @30 = %h", rsp0_rdata);
  endtask

  task automatic test_back_to_back();
    // last winner was port 0, so port 1 takes the tie
    tick();
    rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 32'h20; rq0_maskmode = 2'b10;
    rq1_valid = 1'b1; rq1_write = 1'b0; rq1_addr = 32'h10; rq1_maskmode = 2'b10; #3;
    tests++; if (rq1_ready !== 1'b1 || rq0_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_first: got %b%b want 01", rq0_ready, rq1_ready); end
    tick(); rq1_valid = 1'b0; #3;
    tests++; if (rq0_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_busy: got %b want 0", rq0_ready); end
    tick(); #3;
    tests++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hDEADBEEF || rsp0_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_rsp1: got v1=%b d=%h v0=%b want 1 deadbeef 0", rsp1_valid,
                        rsp1_rdata, rsp0_valid); end
    $display("[TB] txn port1 load word @10 -> %h", rsp1_rdata);
    tick(); #3;
    tests++; if (rq0_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_second: got %b want 1", rq0_ready); end
    tick(); rq0_valid = 1'b0;
    tick(); #3;
    tests++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h112233AB || rsp1_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_rsp0: got v0=%b d=%h v1=%b want 1 112233ab 0", rsp0_valid,
                        rsp0_rdata, rsp1_valid); end
    $display("[TB] txn port0 load word @20 -> %h", rsp0_rdata);
  endtask

  // ---------------- randomized run vs transaction-level model -------------
  task automatic test_random(input int ncyc);
    logic        rv [2], rw [2], rs [2];
    logic [31:0] ra [2], rd [2];
    logic [1:0]  rm [2];
    bit          taken [2];
    int          free_at = 0, lg = 1, g;
    bit          pend = 0, pend_err = 0, acc_on = 0, acc_w = 0, err, e0, e1, ea;
    int          pend_cyc = 0, pend_port = 0, acc_cyc = 0;
    logic [31:0] pend_data = 32'h0, acc_addr = 32'h0, got_d;
    logic        got_e;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0; rw[p] = 1'b0; rs[p] = 1'b0; ra[p] = 32'h0; rd[p] = 32'h0; rm[p] = 2'b00;
      taken[p] = 1'b0;
    end
    tick(); rst = 1'b1; rq0_valid = 1'b0; rq1_valid = 1'b0;
    tick(); rst = 1'b0;
    for (int w = 0; w < 64; w++) preload(8'(w * 4), $urandom);
    for (int n = 0; n < ncyc; n++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (taken[p]) rv[p] = 1'b0;
        taken[p] = 1'b0;
        if (!rv[p] && n < ncyc - 8 && $urandom_range(0, 2) == 0) begin
          rv[p] = 1'b1;
          rw[p] = 1'($urandom_range(0, 1));
          rs[p] = 1'($urandom_range(0, 1));
          rd[p] = $urandom;
          rm[p] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          ra[p] = {24'h0, 8'($urandom_range(0, 255))};
          if ($urandom_range(0, 3) != 0) begin
            if (rm[p] == 2'b10) ra[p][1:0] = 2'b00;
            if (rm[p] == 2'b01) ra[p][0]   = 1'b0;
          end
        end
      end
      rq0_valid = rv[0]; rq0_write = rw[0]; rq0_sext = rs[0]; rq0_addr = ra[0];
      rq0_wdata = rd[0]; rq0_maskmode = rm[0];
      rq1_valid = rv[1]; rq1_write = rw[1]; rq1_sext = rs[1]; rq1_addr = ra[1];
      rq1_wdata = rd[1]; rq1_maskmode = rm[1];
      #3;
      g = -1;
      if (n >= free_at && (rv[0] || rv[1]))
        g = (rv[0] && rv[1]) ? 1 - lg : (rv[0] ? 0 : 1);
      tests++; if (rq0_ready !== (g == 0) || rq1_ready !== (g == 1)) begin
        fails++; $display("FAIL rnd_ready cyc%0d: got %b%b want %b%b", n, rq0_ready, rq1_ready,
                          (g == 0), (g == 1)); end
      e0 = pend && pend_cyc == n && pend_port == 0;
      e1 = pend && pend_cyc == n && pend_port == 1;
      tests++; if (rsp0_valid !== e0 || rsp1_valid !== e1) begin
        fails++; $display("FAIL rnd_rsp_valid cyc%0d: got %b%b want %b%b", n, rsp0_valid, rsp1_valid,
                          e0, e1); end
      if (e0 || e1) begin
        got_d = e0 ? rsp0_rdata : rsp1_rdata;
        got_e = e0 ? rsp0_err : rsp1_err;
        tests++; if (got_d !== pend_data || got_e !== pend_err) begin
          fails++; $display("FAIL rnd_rsp_data cyc%0d port%0d: got d=%h e=%b want d=%h e=%b", n,
                            pend_port, got_d, got_e, pend_data, pend_err); end
        $display("[TB] txn port%0d rdata=%h err=%b", pend_port, got_d, got_e);
        pend = 1'b0;
      end
      ea = acc_on && acc_cyc == n;
      tests++; if (mem_read !== (ea && !acc_w) || mem_write !== (ea && acc_w)) begin
        fails++; $display("FAIL rnd_mem_cmd cyc%0d: got rd=%b wr=%b want %b %b", n, mem_read,
                          mem_write, (ea && !acc_w), (ea && acc_w)); end
      if (ea) begin
        tests++; if (mem_address !== acc_addr) begin
          fails++; $display("FAIL rnd_mem_addr cyc%0d: got %h want %h", n, mem_address, acc_addr); end
        acc_on = 1'b0;
      end
      if (g >= 0) begin
        err = (rm[g] == 2'b11) || (rm[g] == 2'b01 && ra[g][0]) ||
              (rm[g] == 2'b10 && ra[g][1:0] != 2'b00);
        pend = 1'b1; pend_port = g; pend_err = err;
        pend_cyc = n + (err ? 1 : 2);
        pend_data = (err || rw[g]) ? 32'h0 : shadow_read(ra[g][7:0], rm[g], rs[g]);
        if (!err) begin
          if (rw[g]) shadow_write(ra[g][7:0], rm[g], rd[g]);
          acc_on = 1'b1; acc_cyc = n + 1; acc_w = rw[g]; acc_addr = ra[g];
        end
        free_at = n + (err ? 2 : 3);
        lg = g;
        taken[g] = 1'b1;
      end
    end
    tests++; if (pend || acc_on) begin
      fails++; $display("FAIL rnd_drain: got pending=%b access=%b want 0 0", pend, acc_on); end
  endtask

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = 8'h0; pl_word = 32'h0;
    rq0_valid = 1'b0; rq0_write = 1'b0; rq0_sext = 1'b0; rq0_addr = 32'h0;
    rq0_wdata = 32'h0; rq0_maskmode = 2'b00;
    rq1_valid = 1'b0; rq1_write = 1'b0; rq1_sext = 1'b0; rq1_addr = 32'h0;
    rq1_wdata = 32'h0; rq1_maskmode = 2'b00;
    test_reset();
    test_word_load();
    test_byte_store();
    test_alternate();
    test_errors();
    test_reset_in_access();
    test_back_to_back();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
